// File: rtl/nwp_pkg.sv
// Shared types and constants for the nibble-to-word packer.
// Optional feature macro: NWP_PARITY_EN adds a per-entry even-parity bit.
package nwp_pkg;

    localparam int NIB_W             = 4;
    localparam int DEF_NIBS_PER_WORD = 4;
    localparam int FIFO_DEPTH        = 2;
    localparam int DEF_WORD_W        = NIB_W * DEF_NIBS_PER_WORD;
    localparam int DEF_CW            = $clog2(DEF_NIBS_PER_WORD + 1);

    typedef logic [NIB_W-1:0] nib_t;

    // Entry layout for the default word size; the top builds its own for overrides.
    typedef struct packed {
        logic [DEF_WORD_W-1:0] word;
        logic [DEF_CW-1:0]     nibs;
`ifdef NWP_PARITY_EN
        logic                  par;
`endif
    } word_ent_t;

    typedef enum logic {
        ACCUM,
        EMIT
    } nwp_state_e;

endpackage

// File: rtl/nwp_fifo2.sv
// Two-entry FIFO with valid/ready on both sides. A pop in the same cycle frees a
// slot for a push, so a full FIFO still accepts when its head is being taken.
module nwp_fifo2
    import nwp_pkg::*;
#(
    parameter type ent_t = word_ent_t
) (
    input  logic clk,
    input  logic rst_n,
    input  ent_t in_data,
    input  logic in_valid,
    output logic in_ready,
    output ent_t out_data,
    output logic out_valid,
    input  logic out_ready
);

    ent_t       mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push;
    logic       pop;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign in_ready  = (count_q != 2'd2) || pop;
    assign push      = in_valid && in_ready;
    assign out_data  = mem_q[rd_ptr_q];

    // When full, wr_ptr equals rd_ptr, so a push can only overwrite the head while it pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/nibble_word_packer.sv
// Packs a 4-bit nibble stream LSB-first into words, closing early on nib_last,
// and buffers finished words in a 2-entry FIFO. Macro NWP_PARITY_EN adds word_par.
module nibble_word_packer
    import nwp_pkg::*;
#(
    parameter int  NIBS_PER_WORD = DEF_NIBS_PER_WORD,
    localparam int WORD_W        = NIB_W * NIBS_PER_WORD,
    localparam int CW            = $clog2(NIBS_PER_WORD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIB_W-1:0]  nib_data,
    input  logic              nib_valid,
    input  logic              nib_last,
    output logic              nib_ready,
    output logic [WORD_W-1:0] word_data,
    output logic [CW-1:0]     word_nibs,
    output logic              word_valid,
    input  logic              word_ready
`ifdef NWP_PARITY_EN
    ,
    output logic              word_par
`endif
);

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [CW-1:0]     nibs;
`ifdef NWP_PARITY_EN
        logic              par;
`endif
    } ent_t;

    logic [WORD_W-1:0] accum_q;
    logic [CW-1:0]     nib_cnt_q;
    logic [WORD_W-1:0] merged;
    logic              accept;
    logic              last_slot;
    nwp_state_e        state;
    ent_t              push_ent;
    ent_t              head_ent;

    assign accept    = nib_valid && nib_ready;
    assign last_slot = (nib_cnt_q == CW'(NIBS_PER_WORD - 1));

    // EMIT exists only in the accept cycle of a closing nibble; it is not registered.
    always_comb begin
        state    = ACCUM;
        merged   = accum_q;
        push_ent = '0;
        for (int k = 0; k < NIBS_PER_WORD; k++) begin
            if (nib_cnt_q == CW'(k)) begin
                merged[NIB_W*k +: NIB_W] = nib_data;
            end
        end
        if (accept && (last_slot || nib_last)) begin
            state = EMIT;
        end
        push_ent.word = merged;
        push_ent.nibs = nib_cnt_q + CW'(1);
`ifdef NWP_PARITY_EN
        // Unused slots are zero, so reducing the whole word covers only valid nibbles.
        push_ent.par  = ^merged;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accum_q   <= '0;
            nib_cnt_q <= '0;
        end else if (accept) begin
            if (state == EMIT) begin
                accum_q   <= '0;
                nib_cnt_q <= '0;
            end else begin
                accum_q   <= merged;
                nib_cnt_q <= nib_cnt_q + CW'(1);
            end
        end
    end

    nwp_fifo2 #(
        .ent_t (ent_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (push_ent),
        .in_valid  (state == EMIT),
        .in_ready  (nib_ready),
        .out_data  (head_ent),
        .out_valid (word_valid),
        .out_ready (word_ready)
    );

    assign word_data = head_ent.word;
    assign word_nibs = head_ent.nibs;
`ifdef NWP_PARITY_EN
    assign word_par  = head_ent.par;
`endif

endmodule

// File: tb/tb_nibble_word_packer.sv
// Self-checking bench for nibble_word_packer (4 nibbles per word): directed
// scenarios plus a randomized stream scored against a queue-based word model.
module tb_nibble_word_packer;

    localparam int N  = 4;
    localparam int WW = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    nib_data = '0;
    logic          nib_valid = 1'b0;
    logic          nib_last = 1'b0;
    logic          nib_ready;
    logic [WW-1:0] word_data;
    logic [CW-1:0] word_nibs;
    logic          word_valid;
    logic          word_ready = 1'b0;
`ifdef NWP_PARITY_EN
    logic          word_par;
`endif

    logic [WW-1:0] exp_q[$];
    int            exp_n[$];
    logic [3:0]    cur_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic          rand_ready = 1'b0;

    always #5 clk = ~clk;

    nibble_word_packer #(.NIBS_PER_WORD(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nib_data   (nib_data),
        .nib_valid  (nib_valid),
        .nib_last   (nib_last),
        .nib_ready  (nib_ready),
        .word_data  (word_data),
        .word_nibs  (word_nibs),
        .word_valid (word_valid),
        .word_ready (word_ready)
`ifdef NWP_PARITY_EN
        ,
        .word_par   (word_par)
`endif
    );

    // Reference model: collect accepted nibbles; a word closes at N nibbles or on last.
    task automatic model_accept(input logic [3:0] d, input logic last);
        logic [WW-1:0] w;
        int            sz;
        cur_q.push_back(d);
        if (last || cur_q.size() == N) begin
            w  = '0;
            sz = cur_q.size();
            for (int k = 0; k < sz; k++) w = w + WW'(cur_q[k]) * WW'(16 ** k);
            exp_q.push_back(w);
            exp_n.push_back(sz);
            cur_q.delete();
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        exp_n.delete();
        cur_q.delete();
    endtask

    // Falling edge: score any word handshake that the next rising edge will complete.
    task automatic tick_neg();
        logic [WW-1:0] ew;
        int            en;
        @(negedge clk);
        if (rst_n && word_valid && word_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra_word got=%h nibs=%0d required=none", word_data, word_nibs);
            end else begin
                ew = exp_q.pop_front();
                en = exp_n.pop_front();
                if (word_data !== ew || word_nibs !== CW'(en)) begin
                    n_err++;
                    $display("FAIL sb_word got=%h/%0d required=%h/%0d", word_data, word_nibs, ew, en);
                end
`ifdef NWP_PARITY_EN
                n_cmp++;
                if (word_par !== 1'(($countones(ew) % 2) == 1)) begin
                    n_err++;
                    $display("FAIL sb_par word=%h got=%b required=%b", ew, word_par,
                             1'(($countones(ew) % 2) == 1));
                end
`endif
            end
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
        if (rand_ready) word_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic cycle();
        tick_neg();
        post_edge();
    endtask

    task automatic send_nib(input logic [3:0] d, input logic last);
        int w;
        w = 0;
        nib_data  = d;
        nib_last  = last;
        nib_valid = 1'b1;
        tick_neg();
        while (!nib_ready && w < 200) begin
            post_edge();
            tick_neg();
            w++;
        end
        if (nib_ready) begin
            model_accept(d, last);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout nib_ready=0 for %0d cycles required=1", w);
        end
        post_edge();
        nib_valid = 1'b0;
        nib_last  = 1'b0;
        nib_data  = '0;
    endtask

    task automatic test_reset();
        post_edge();
        n_cmp++;
        if (word_valid !== 1'b0 || word_data !== '0 || word_nibs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b d=%h n=%0d required 0/0000/0",
                     word_valid, word_data, word_nibs);
        end
        rst_n = 1'b1;
        tick_neg();
        n_cmp++;
        if (nib_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_nib_ready got=%b required=1", nib_ready);
        end
        post_edge();
    endtask

    task automatic test_full_word();
        word_ready = 1'b1;
        send_nib(4'h1, 1'b0);
        send_nib(4'h2, 1'b0);
        send_nib(4'h3, 1'b0);
        n_cmp++;
        if (word_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_early_valid got=%b required=0", word_valid);
        end
        send_nib(4'h4, 1'b0);
        n_cmp++;
        if (word_valid !== 1'b1 || word_data !== 16'h4321 || word_nibs !== 3'd4) begin
            n_err++;
            $display("FAIL full_latency got v=%b d=%h n=%0d required 1/4321/4",
                     word_valid, word_data, word_nibs);
        end
        cycle();
    endtask

    task automatic test_partial();
        send_nib(4'hA, 1'b0);
        send_nib(4'hB, 1'b1);
        n_cmp++;
        if (word_valid !== 1'b1 || word_data !== 16'h00BA || word_nibs !== 3'd2) begin
            n_err++;
            $display("FAIL partial_word got v=%b d=%h n=%0d required 1/00ba/2",
                     word_valid, word_data, word_nibs);
        end
        send_nib(4'hC, 1'b0);
        send_nib(4'hD, 1'b0);
        send_nib(4'hE, 1'b0);
        send_nib(4'hF, 1'b0);
        n_cmp++;
        if (word_data !== 16'hFEDC || word_nibs !== 3'd4) begin
            n_err++;
            $display("FAIL partial_restart got d=%h n=%0d required fedc/4", word_data, word_nibs);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_nib(4'(i), 1'b0);
        n_cmp++;
        if (nib_ready !== 1'b0 || word_data !== 16'h3210) begin
            n_err++;
            $display("FAIL bp_full got rdy=%b d=%h required 0/3210", nib_ready, word_data);
        end
        repeat (3) cycle();
        n_cmp++;
        if (word_valid !== 1'b1 || word_data !== 16'h3210 || nib_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold got v=%b d=%h rdy=%b required 1/3210/0",
                     word_valid, word_data, nib_ready);
        end
        word_ready = 1'b1;
        for (int i = 8; i < 12; i++) send_nib(4'(i), 1'b0);
        repeat (2) cycle();
        n_cmp++;
        if (exp_q.size() != 0 || word_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain pending=%0d v=%b required 0/0", exp_q.size(), word_valid);
        end
    endtask

    task automatic test_last_on_full();
        send_nib(4'hF, 1'b0);
        send_nib(4'hE, 1'b0);
        send_nib(4'hD, 1'b0);
        send_nib(4'hC, 1'b1);
        n_cmp++;
        if (word_data !== 16'hCDEF || word_nibs !== 3'd4) begin
            n_err++;
            $display("FAIL last_full_word got d=%h n=%0d required cdef/4", word_data, word_nibs);
        end
        repeat (2) cycle();
        n_cmp++;
        if (word_valid !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL last_no_empty got v=%b pending=%0d required 0/0", word_valid, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        word_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send_nib(4'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (word_valid !== 1'b0 || word_data !== '0) begin
            n_err++;
            $display("FAIL mid_reset got v=%b d=%h required 0/0000", word_valid, word_data);
        end
        model_flush();
        post_edge();
        rst_n = 1'b1;
        word_ready = 1'b1;
        for (int i = 5; i <= 8; i++) send_nib(4'(i), 1'b0);
        n_cmp++;
        if (word_valid !== 1'b1 || word_data !== 16'h8765 || word_nibs !== 3'd4) begin
            n_err++;
            $display("FAIL mid_reset_after got v=%b d=%h n=%0d required 1/8765/4",
                     word_valid, word_data, word_nibs);
        end
        cycle();
    endtask

`ifdef NWP_PARITY_EN
    task automatic test_parity();
        word_ready = 1'b1;
        send_nib(4'h1, 1'b0);
        repeat (3) send_nib(4'h0, 1'b0);
        n_cmp++;
        if (word_data !== 16'h0001 || word_par !== 1'b1) begin
            n_err++;
            $display("FAIL parity_odd got d=%h p=%b required 0001/1", word_data, word_par);
        end
        cycle();
        send_nib(4'h3, 1'b0);
        repeat (3) send_nib(4'h0, 1'b0);
        n_cmp++;
        if (word_data !== 16'h0003 || word_par !== 1'b0) begin
            n_err++;
            $display("FAIL parity_even got d=%h p=%b required 0003/0", word_data, word_par);
        end
        cycle();
    endtask
`endif

    task automatic test_random();
        int gap;
        int w;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            gap = $urandom_range(0, 3);
            if (gap == 3) cycle();
            send_nib(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0) || (i == 299));
        end
        rand_ready = 1'b0;
        word_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            cycle();
            w++;
        end
        cycle();
        n_cmp++;
        if (exp_q.size() != 0 || word_valid !== 1'b0 || cur_q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain pending=%0d v=%b required 0/0", exp_q.size(), word_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_last_on_full();
        test_mid_reset();
`ifdef NWP_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
